// File: rtl/gctr_frame_sequencer.sv
// Upstream control stage for the GCTR block: sequences IV -> pre-cipher -> data words,
// generates J0-derived pre-blocks and initial counter block, the len(C) bit count and a
// sticky counter-overflow flag.
module gctr_frame_sequencer #(
    parameter int unsigned NB_BLOCK  = 128,
    parameter int unsigned N_BLOCKS  = 2,
    parameter int unsigned NB_DATA   = N_BLOCKS * NB_BLOCK,
    parameter int unsigned NB_NBYTES = 6
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [95:0]          i_iv,
    input  logic                 i_iv_valid,
    output logic                 o_iv_ready,
    input  logic [NB_DATA-1:0]   i_data,
    input  logic                 i_data_valid,
    input  logic                 i_data_last,
    input  logic [NB_NBYTES-1:0] i_data_nbytes,
    output logic                 o_data_ready,
    output logic [NB_DATA-1:0]   o_plaintext_words_x,
    output logic                 o_valid,
    output logic                 o_sop,
    output logic                 o_sop_pre,
    output logic [NB_DATA-1:0]   o_pre_blocks,
    output logic [NB_BLOCK-1:0]  o_initial_counter_block,
    output logic [63:0]          o_len_c_bits,
    output logic                 o_len_valid,
    output logic                 o_ctr_overflow
);

    localparam int unsigned NbytesMax = NB_DATA / 8;
    // Largest block count that still fits the 32-bit counter field.
    localparam logic [32:0] CtrMax = 33'h0_FFFF_FFFE;

    typedef enum logic [1:0] {StIdle, StPre, StWait, StData} state_e;

    state_e                state_q, state_d;
    logic [NB_BLOCK-1:0]   j0_q, j0_d;
    logic [32:0]           blk_cnt_q, blk_cnt_d;
    logic [63:0]           word_cnt_q, word_cnt_d;
    logic                  ovf_q, ovf_d;
    logic [NB_DATA-1:0]    plain_q, plain_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  sop_pre_q, sop_pre_d;
    logic [NB_DATA-1:0]    pre_blocks_q, pre_blocks_d;
    logic [NB_BLOCK-1:0]   icb_q, icb_d;
    logic [63:0]           len_q, len_d;
    logic                  len_valid_q, len_valid_d;
    logic                  iv_ready, data_ready;
    logic [32:0]           blk_cnt_nxt;
    logic [NB_NBYTES-1:0]  nbytes_eff;

    // Out-of-range byte counts on the last word mean a full word.
    always_comb begin
        nbytes_eff = i_data_nbytes;
        if (i_data_nbytes == '0 || 32'(i_data_nbytes) > NbytesMax) begin
            nbytes_eff = NB_NBYTES'(NbytesMax);
        end
    end

    assign blk_cnt_nxt = blk_cnt_q + 33'(N_BLOCKS);

    // Next-state, handshake and registered-output computation.
    always_comb begin
        state_d      = state_q;
        j0_d         = j0_q;
        blk_cnt_d    = blk_cnt_q;
        word_cnt_d   = word_cnt_q;
        ovf_d        = ovf_q;
        plain_d      = plain_q;
        valid_d      = 1'b0;
        sop_d        = 1'b0;
        sop_pre_d    = 1'b0;
        pre_blocks_d = pre_blocks_q;
        icb_d        = icb_q;
        len_d        = len_q;
        len_valid_d  = 1'b0;
        iv_ready     = 1'b0;
        data_ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                iv_ready = 1'b1;
                if (i_iv_valid) begin
                    j0_d       = {i_iv, 31'b0, 1'b1};
                    blk_cnt_d  = '0;
                    word_cnt_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = StPre;
                end
            end
            StPre: begin
                sop_pre_d                           = 1'b1;
                pre_blocks_d                        = '0;
                pre_blocks_d[NB_BLOCK +: NB_BLOCK]  = j0_q;
                icb_d   = {j0_q[NB_BLOCK-1:32], j0_q[31:0] + 32'd1};
                state_d = StWait;
            end
            StWait, StData: begin
                data_ready = 1'b1;
                if (i_data_valid) begin
                    plain_d    = i_data;
                    valid_d    = 1'b1;
                    sop_d      = (state_q == StWait);
                    blk_cnt_d  = blk_cnt_nxt;
                    word_cnt_d = word_cnt_q + 64'd1;
                    if (blk_cnt_nxt > CtrMax) begin
                        ovf_d = 1'b1;
                    end
                    if (i_data_last) begin
                        len_d       = (word_cnt_q * 64'(NB_DATA)) + (64'(nbytes_eff) << 3);
                        len_valid_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= StIdle;
            j0_q         <= '0;
            blk_cnt_q    <= '0;
            word_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            plain_q      <= '0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            sop_pre_q    <= 1'b0;
            pre_blocks_q <= '0;
            icb_q        <= '0;
            len_q        <= '0;
            len_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            j0_q         <= j0_d;
            blk_cnt_q    <= blk_cnt_d;
            word_cnt_q   <= word_cnt_d;
            ovf_q        <= ovf_d;
            plain_q      <= plain_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            sop_pre_q    <= sop_pre_d;
            pre_blocks_q <= pre_blocks_d;
            icb_q        <= icb_d;
            len_q        <= len_d;
            len_valid_q  <= len_valid_d;
        end
    end

    assign o_iv_ready              = iv_ready;
    assign o_data_ready            = data_ready;
    assign o_plaintext_words_x     = plain_q;
    assign o_valid                 = valid_q;
    assign o_sop                   = sop_q;
    assign o_sop_pre               = sop_pre_q;
    assign o_pre_blocks            = pre_blocks_q;
    assign o_initial_counter_block = icb_q;
    assign o_len_c_bits            = len_q;
    assign o_len_valid             = len_valid_q;
    assign o_ctr_overflow          = ovf_q;

endmodule

// File: tb/tb_gctr_frame_sequencer.sv
// Directed self-checking bench for gctr_frame_sequencer.
module tb_gctr_frame_sequencer;

    localparam int unsigned NbData = 256;

    logic              i_clock = 1'b0;
    logic              i_reset;
    logic [95:0]       i_iv;
    logic              i_iv_valid;
    logic              o_iv_ready;
    logic [NbData-1:0] i_data;
    logic              i_data_valid;
    logic              i_data_last;
    logic [5:0]        i_data_nbytes;
    logic              o_data_ready;
    logic [NbData-1:0] o_plaintext_words_x;
    logic              o_valid;
    logic              o_sop;
    logic              o_sop_pre;
    logic [NbData-1:0] o_pre_blocks;
    logic [127:0]      o_initial_counter_block;
    logic [63:0]       o_len_c_bits;
    logic              o_len_valid;
    logic              o_ctr_overflow;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [95:0]  Iv    = 96'hCAFEBABEFACEDBADDECAF888;
    localparam logic [127:0] J0    = {96'hCAFEBABEFACEDBADDECAF888, 32'h0000_0001};
    localparam logic [127:0] Icb   = {96'hCAFEBABEFACEDBADDECAF888, 32'h0000_0002};
    localparam logic [95:0]  Iv2   = 96'h0123456789ABCDEF00000000;
    localparam logic [127:0] Icb2  = {96'h0123456789ABCDEF00000000, 32'h0000_0002};
    localparam logic [255:0] WordA = {8{32'hA5A5_0001}};
    localparam logic [255:0] WordB = {8{32'h5A5A_0002}};
    localparam logic [255:0] WordC = {8{32'h1234_0003}};

    gctr_frame_sequencer dut (
        .i_clock                 (i_clock),
        .i_reset                 (i_reset),
        .i_iv                    (i_iv),
        .i_iv_valid              (i_iv_valid),
        .o_iv_ready              (o_iv_ready),
        .i_data                  (i_data),
        .i_data_valid            (i_data_valid),
        .i_data_last             (i_data_last),
        .i_data_nbytes           (i_data_nbytes),
        .o_data_ready            (o_data_ready),
        .o_plaintext_words_x     (o_plaintext_words_x),
        .o_valid                 (o_valid),
        .o_sop                   (o_sop),
        .o_sop_pre               (o_sop_pre),
        .o_pre_blocks            (o_pre_blocks),
        .o_initial_counter_block (o_initial_counter_block),
        .o_len_c_bits            (o_len_c_bits),
        .o_len_valid             (o_len_valid),
        .o_ctr_overflow          (o_ctr_overflow)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle_inputs();
        i_iv_valid    = 1'b0;
        i_data_valid  = 1'b0;
        i_data_last   = 1'b0;
        i_data_nbytes = '0;
    endtask

    // Offer an IV for one edge, then step through PRE; leaves DUT in WAIT with o_sop_pre high.
    task automatic start_frame(input logic [95:0] iv);
        i_iv       = iv;
        i_iv_valid = 1'b1;
        tick();
        i_iv_valid = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [255:0] d, input logic last, input logic [5:0] nb);
        i_data        = d;
        i_data_valid  = 1'b1;
        i_data_last   = last;
        i_data_nbytes = nb;
        tick();
        idle_inputs();
    endtask

    initial begin
        // T1: reset with stimuli active
        i_reset       = 1'b1;
        i_iv          = Iv;
        i_iv_valid    = 1'b1;
        i_data        = WordA;
        i_data_valid  = 1'b1;
        i_data_last   = 1'b1;
        i_data_nbytes = 6'd7;
        repeat (3) tick();
        check_eq("rst_iv_ready", 256'(o_iv_ready), 256'd1);
        check_eq("rst_data_ready", 256'(o_data_ready), 256'd0);
        check_eq("rst_valid_sop", 256'({o_valid, o_sop, o_sop_pre, o_len_valid}), 256'd0);
        check_eq("rst_plain", o_plaintext_words_x, 256'd0);
        check_eq("rst_pre_blocks", o_pre_blocks, 256'd0);
        check_eq("rst_icb", 256'(o_initial_counter_block), 256'd0);
        check_eq("rst_len", 256'(o_len_c_bits), 256'd0);
        check_eq("rst_ovf", 256'(o_ctr_overflow), 256'd0);
        i_reset = 1'b0;
        idle_inputs();
        tick();

        // T2: single full word frame
        i_iv       = Iv;
        i_iv_valid = 1'b1;
        tick();
        i_iv_valid = 1'b0;
        check_eq("t2_pre_no_ready", 256'({o_iv_ready, o_data_ready}), 256'd0);
        check_eq("t2_pre_no_sop_pre", 256'(o_sop_pre), 256'd0);
        tick();
        check_eq("t2_sop_pre", 256'(o_sop_pre), 256'd1);
        check_eq("t2_pre_blocks", o_pre_blocks, {J0, 128'd0});
        check_eq("t2_icb", 256'(o_initial_counter_block), 256'(Icb));
        check_eq("t2_wait_ready", 256'(o_data_ready), 256'd1);
        check_eq("t2_no_valid_yet", 256'(o_valid), 256'd0);
        send_word(WordA, 1'b1, 6'd32);
        check_eq("t2_valid_sop", 256'({o_valid, o_sop, o_sop_pre}), 256'b110);
        check_eq("t2_plain", o_plaintext_words_x, WordA);
        check_eq("t2_len_valid", 256'(o_len_valid), 256'd1);
        check_eq("t2_len", 256'(o_len_c_bits), 256'd256);
        check_eq("t2_ovf", 256'(o_ctr_overflow), 256'd0);
        check_eq("t2_back_idle", 256'(o_iv_ready), 256'd1);
        tick();
        check_eq("t2_pulses_end", 256'({o_valid, o_sop, o_len_valid}), 256'd0);
        check_eq("t2_plain_hold", o_plaintext_words_x, WordA);

        // T3: three words, stall mid-frame, last nbytes=5
        start_frame(Iv2);
        check_eq("t3_icb", 256'(o_initial_counter_block), 256'(Icb2));
        send_word(WordA, 1'b0, 6'd0);
        check_eq("t3_w1", 256'({o_valid, o_sop, o_len_valid}), 256'b110);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("t3_stall_valid", 256'(o_valid), 256'd0);
            check_eq("t3_stall_ready", 256'(o_data_ready), 256'd1);
        end
        send_word(WordB, 1'b0, 6'd0);
        check_eq("t3_w2", 256'({o_valid, o_sop, o_len_valid}), 256'b100);
        check_eq("t3_w2_data", o_plaintext_words_x, WordB);
        send_word(WordC, 1'b1, 6'd5);
        check_eq("t3_w3", 256'({o_valid, o_sop, o_len_valid}), 256'b101);
        check_eq("t3_len", 256'(o_len_c_bits), 256'd552);

        // T4: data offered from the IV cycle onward; nbytes=0 means full word
        tick();
        i_iv          = Iv;
        i_iv_valid    = 1'b1;
        i_data        = WordC;
        i_data_valid  = 1'b1;
        i_data_last   = 1'b1;
        i_data_nbytes = 6'd0;
        tick();
        i_iv_valid = 1'b0;
        check_eq("t4_pre_valid", 256'(o_valid), 256'd0);
        check_eq("t4_pre_ready", 256'(o_data_ready), 256'd0);
        tick();
        check_eq("t4_sop_pre_only", 256'({o_sop_pre, o_valid}), 256'b10);
        tick();
        idle_inputs();
        check_eq("t4_first_word", 256'({o_sop_pre, o_valid, o_sop}), 256'b011);
        check_eq("t4_data", o_plaintext_words_x, WordC);
        check_eq("t4_len", 256'(o_len_c_bits), 256'd256);
        tick();
        check_eq("t4_single_word", 256'(o_valid), 256'd0);

        // T5: counter overflow, cleared by next IV
        start_frame(Iv);
        force dut.blk_cnt_q = 33'h0_FFFF_FFFD;
        i_data        = WordB;
        i_data_valid  = 1'b1;
        i_data_last   = 1'b0;
        tick();
        release dut.blk_cnt_q;
        idle_inputs();
        check_eq("t5_ovf_set", 256'(o_ctr_overflow), 256'd1);
        check_eq("t5_data_flows", 256'(o_valid), 256'd1);
        send_word(WordA, 1'b1, 6'd32);
        check_eq("t5_ovf_sticky", 256'(o_ctr_overflow), 256'd1);
        i_iv       = Iv;
        i_iv_valid = 1'b1;
        tick();
        i_iv_valid = 1'b0;
        check_eq("t5_ovf_cleared", 256'(o_ctr_overflow), 256'd0);
        tick();

        // T6: reset mid-frame, then a normal frame
        send_word(WordA, 1'b0, 6'd0);
        send_word(WordB, 1'b0, 6'd0);
        check_eq("t6_w2", 256'({o_valid, o_sop}), 256'b10);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_eq("t6_rst_outs", 256'({o_valid, o_sop, o_len_valid, o_data_ready}), 256'd0);
        check_eq("t6_rst_iv_ready", 256'(o_iv_ready), 256'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_no_len_valid", 256'(o_len_valid), 256'd0);
        end
        start_frame(Iv2);
        check_eq("t6_sop_pre", 256'(o_sop_pre), 256'd1);
        send_word(WordC, 1'b1, 6'd1);
        check_eq("t6_word", 256'({o_valid, o_sop, o_len_valid}), 256'b111);
        check_eq("t6_len", 256'(o_len_c_bits), 256'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
